// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - XGA 1024x768 timing constants and shared helpers.
package vga_timing_pkg;

  // Width at which every counter/region comparison is made, for both axes.
  localparam int CMP_W = 11;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  localparam bit XGA_H_SYNC_POL = 1'b0;
  localparam bit XGA_V_SYNC_POL = 1'b0;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int XGA_H_TOTAL = axis_total(XGA_H_ACTIVE, XGA_H_FP, XGA_H_SYNC, XGA_H_BP);
  localparam int XGA_V_TOTAL = axis_total(XGA_V_ACTIVE, XGA_V_FP, XGA_V_SYNC, XGA_V_BP);

  function automatic logic sync_level(input logic in_region, input logic pol);
    return in_region ? pol : ~pol;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one video axis: wrapping counter plus active/sync region decode.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = XGA_H_ACTIVE,
  parameter int FP     = XGA_H_FP,
  parameter int SYNC   = XGA_H_SYNC,
  parameter int BP     = XGA_H_BP,
  parameter int CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync_region
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CMP_W-1:0] C_LAST      = CMP_W'(TOTAL - 1);
  localparam logic [CMP_W-1:0] C_ACT_END   = CMP_W'(ACTIVE);
  localparam logic [CMP_W-1:0] C_SYNC_BEG  = CMP_W'(ACTIVE + FP);
  localparam logic [CMP_W-1:0] C_SYNC_END  = CMP_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] r_cnt;
  logic [CMP_W-1:0] w_cnt_cmp;

  // Zero-extend so both axes decode with identical unsigned compares.
  assign w_cnt_cmp = CMP_W'(r_cnt);
  assign o_wrap    = (w_cnt_cmp == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      if (o_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt         = r_cnt;
  assign o_active      = (w_cnt_cmp < C_ACT_END);
  assign o_sync_region = (w_cnt_cmp >= C_SYNC_BEG) && (w_cnt_cmp < C_SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - video timing generator; registered sync, active, coordinates and strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = XGA_H_ACTIVE,
  parameter int H_FP       = XGA_H_FP,
  parameter int H_SYNC     = XGA_H_SYNC,
  parameter int H_BP       = XGA_H_BP,
  parameter int V_ACTIVE   = XGA_V_ACTIVE,
  parameter int V_FP       = XGA_V_FP,
  parameter int V_SYNC     = XGA_V_SYNC,
  parameter int V_BP       = XGA_V_BP,
  parameter bit H_SYNC_POL = XGA_H_SYNC_POL,
  parameter bit V_SYNC_POL = XGA_V_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_active,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start
);

  logic [10:0] w_h_cnt;
  logic [9:0]  w_v_cnt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_h_active;
  logic        w_v_active;
  logic        w_hs_region;
  logic        w_vs_region;
  logic        w_v_inc;
  logic        w_active;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (11)
  ) u_h_axis (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (ce),
    .o_cnt         (w_h_cnt),
    .o_wrap        (w_h_wrap),
    .o_active      (w_h_active),
    .o_sync_region (w_hs_region)
  );

  // The vertical axis steps once per line, on the enabled horizontal wrap.
  assign w_v_inc = ce & w_h_wrap;

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (10)
  ) u_v_axis (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (w_v_inc),
    .o_cnt         (w_v_cnt),
    .o_wrap        (w_v_wrap),
    .o_active      (w_v_active),
    .o_sync_region (w_vs_region)
  );

  assign w_active = w_h_active & w_v_active;

  // All outputs lag the counters by one enabled cycle and move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= ~H_SYNC_POL;
      vsync        <= ~V_SYNC_POL;
      video_active <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (ce) begin
      hsync        <= sync_level(w_hs_region, H_SYNC_POL);
      vsync        <= sync_level(w_vs_region, V_SYNC_POL);
      video_active <= w_active;
      pix_x        <= w_active ? w_h_cnt[9:0] : 10'd0;
      pix_y        <= w_active ? w_v_cnt : 10'd0;
      line_start   <= (w_h_cnt == 11'd0);
      frame_start  <= (w_h_cnt == 11'd0) && (w_v_cnt == 10'd0);
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (XGA and small timing sets).
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ce;
  logic       hsync, vsync, video_active, line_start, frame_start;
  logic [9:0] pix_x, pix_y;

  logic       s_rst_n, s_ce;
  logic       s_hsync, s_vsync, s_video_active, s_line_start, s_frame_start;
  logic [9:0] s_pix_x, s_pix_y;

  vga_timing_gen u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_active (video_active),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .line_start   (line_start),
    .frame_start  (frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_small (
    .clk          (clk),
    .rst_n        (s_rst_n),
    .ce           (s_ce),
    .hsync        (s_hsync),
    .vsync        (s_vsync),
    .video_active (s_video_active),
    .pix_x        (s_pix_x),
    .pix_y        (s_pix_y),
    .line_start   (s_line_start),
    .frame_start  (s_frame_start)
  );

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Packed layout: {hsync, vsync, active, line_start, frame_start, x, y}
  function automatic logic [24:0] pack(logic hs, logic vs, logic act, logic ls,
                                       logic fs, logic [9:0] x, logic [9:0] y);
    return {hs, vs, act, ls, fs, x, y};
  endfunction

  function automatic logic [24:0] big_out();
    return pack(hsync, vsync, video_active, line_start, frame_start, pix_x, pix_y);
  endfunction

  function automatic logic [24:0] small_out();
    return pack(s_hsync, s_vsync, s_video_active, s_line_start, s_frame_start, s_pix_x, s_pix_y);
  endfunction

  // Expected small-DUT outputs after the k-th enabled edge since reset (14x7 frame).
  function automatic logic [24:0] small_exp(int k);
    int  n, h, v;
    logic act;
    n   = k - 1;
    h   = n % 14;
    v   = (n / 14) % 7;
    act = (h < 8) && (v < 4);
    return pack(!((h >= 10) && (h < 12)), !(v == 5), act, h == 0, (h == 0) && (v == 0),
                act ? 10'(h) : 10'd0, act ? 10'(v) : 10'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(int k, logic [9:0] x, logic [9:0] y, logic act, logic hs,
                         logic vs, logic ls, logic fs);
    vec_t v;
    v.k = k; v.x = x; v.y = y; v.act = act; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
    vecs.push_back(v);
  endtask

  task automatic small_frame_check(input string name, input int nedges);
    int n_fs, n_vs_low, n_ls;
    n_fs = 0; n_vs_low = 0; n_ls = 0;
    for (int k = 1; k <= nedges; k++) begin
      tick();
      check(name, 32'(small_out()), 32'(small_exp(k)));
      if (s_frame_start) n_fs++;
      if (!s_vsync) n_vs_low++;
      if (s_line_start) n_ls++;
    end
    check({name, "_fs_count"}, n_fs, nedges / 98);
    check({name, "_vs_low_count"}, n_vs_low, (nedges / 98) * 14);
    check({name, "_ls_count"}, n_ls, nedges / 14);
  endtask

  initial begin
    int k;
    int n_act, n_hs, n_ls;
    logic [24:0] prev;

    rst_n = 1'b0; ce = 1'b1;
    s_rst_n = 1'b0; s_ce = 1'b0;
    repeat (3) tick();
    check("reset_state", 32'(big_out()), 32'(pack(1, 1, 0, 0, 0, 10'd0, 10'd0)));
    check("small_reset_state", 32'(small_out()), 32'(pack(1, 1, 0, 0, 0, 10'd0, 10'd0)));

    add_vec(1,    10'd0,    10'd0, 1, 1, 1, 1, 1);
    add_vec(2,    10'd1,    10'd0, 1, 1, 1, 0, 0);
    add_vec(1024, 10'd1023, 10'd0, 1, 1, 1, 0, 0);
    add_vec(1025, 10'd0,    10'd0, 0, 1, 1, 0, 0);
    add_vec(1048, 10'd0,    10'd0, 0, 1, 1, 0, 0);
    add_vec(1049, 10'd0,    10'd0, 0, 0, 1, 0, 0);
    add_vec(1184, 10'd0,    10'd0, 0, 0, 1, 0, 0);
    add_vec(1185, 10'd0,    10'd0, 0, 1, 1, 0, 0);
    add_vec(1344, 10'd0,    10'd0, 0, 1, 1, 0, 0);
    add_vec(1345, 10'd0,    10'd1, 1, 1, 1, 1, 0);
    add_vec(1346, 10'd1,    10'd1, 1, 1, 1, 0, 0);
    add_vec(2368, 10'd1023, 10'd1, 1, 1, 1, 0, 0);
    add_vec(2689, 10'd0,    10'd2, 1, 1, 1, 1, 0);
    add_vec(3189, 10'd500,  10'd2, 1, 1, 1, 0, 0);

    // XGA instance: first lines, table driven.
    rst_n = 1'b1;
    k = 0; n_act = 0; n_hs = 0; n_ls = 0;
    foreach (vecs[i]) begin
      while (k < vecs[i].k) begin
        tick();
        k++;
        if (k <= 1344) begin
          if (video_active) n_act++;
          if (!hsync) n_hs++;
        end
        if (k <= 2688 && line_start) n_ls++;
      end
      check($sformatf("xga_vec_k%0d", vecs[i].k), 32'(big_out()),
            32'(pack(vecs[i].hs, vecs[i].vs, vecs[i].act, vecs[i].ls, vecs[i].fs,
                     vecs[i].x, vecs[i].y)));
    end
    check("xga_line0_active_count", n_act, 1024);
    check("xga_line0_hsync_low_count", n_hs, 136);
    check("xga_two_line_ls_count", n_ls, 2);

    // Asynchronous reset mid-line takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("xga_async_reset", 32'(big_out()), 32'(pack(1, 1, 0, 0, 0, 10'd0, 10'd0)));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("xga_restart_first", 32'(big_out()), 32'(pack(1, 1, 1, 1, 1, 10'd0, 10'd0)));
    tick();
    check("xga_restart_second", 32'(big_out()), 32'(pack(1, 1, 1, 0, 0, 10'd1, 10'd0)));

    // Small instance: two full frames compared on every edge.
    s_ce = 1'b1;
    s_rst_n = 1'b1;
    small_frame_check("small_frames", 196);

    // Reset during the vsync line, then a clean frame with no partial pulse.
    s_rst_n = 1'b0;
    tick();
    s_rst_n = 1'b1;
    for (int i = 1; i <= 74; i++) tick();
    check("small_in_vsync", 32'(small_out()), 32'(small_exp(74)));
    #2 s_rst_n = 1'b0;
    #1;
    check("small_async_reset", 32'(small_out()), 32'(pack(1, 1, 0, 0, 0, 10'd0, 10'd0)));
    tick();
    s_rst_n = 1'b1;
    small_frame_check("small_after_reset", 98);

    // ce toggling: each enabled edge follows the normal sequence, disabled edges hold.
    s_rst_n = 1'b0;
    tick();
    s_rst_n = 1'b1;
    k = 0; n_ls = 0; n_act = 0;
    prev = small_out();
    for (int i = 0; i < 196; i++) begin
      s_ce = (i % 2 == 0);
      tick();
      if (s_ce) begin
        k++;
        check("ce_toggle_on", 32'(small_out()), 32'(small_exp(k)));
      end else begin
        check("ce_toggle_hold", 32'(small_out()), 32'({prev[24:22], 2'b00, prev[19:0]}));
      end
      if (s_line_start) n_ls++;
      if (s_frame_start) n_act++;
      prev = small_out();
    end
    check("ce_toggle_ls_count", n_ls, 7);
    check("ce_toggle_fs_count", n_act, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
